// File: rtl/playfield_writer_pkg.sv
// Shared definitions for the playfield tile-RAM write engine: register
// indices, FSM state encoding, status bit positions and default widths.
package playfield_writer_pkg;

    localparam int PF_ADDR_W_DEFAULT = 10;
    localparam int TILE_W_DEFAULT    = 8;

    // CPU register indices within I/O region 2
    localparam logic [1:0] REG_CURSOR   = 2'd0;
    localparam logic [1:0] REG_DATA     = 2'd1;
    localparam logic [1:0] REG_FILL_LEN = 2'd2;
    localparam logic [1:0] REG_FILL_GO  = 2'd3;

    // Bit positions inside the status register
    localparam int STAT_BUSY     = 0;
    localparam int STAT_EMPTY    = 1;
    localparam int STAT_FULL     = 2;
    localparam int STAT_OVERFLOW = 3;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } pw_state_e;

    // Assemble the status nibble so the bit positions live in one place
    function automatic logic [3:0] pack_status(input logic ovf,
                                               input logic full,
                                               input logic empty,
                                               input logic bsy);
        logic [3:0] s;
        s                = 4'b0000;
        s[STAT_OVERFLOW] = ovf;
        s[STAT_FULL]     = full;
        s[STAT_EMPTY]    = empty;
        s[STAT_BUSY]     = bsy;
        return s;
    endfunction

endpackage

// File: rtl/playfield_writer_fifo.sv
// pw_fifo: single-clock synchronous FIFO holding queued tile writes.
// A push while full is refused even when a pop happens in the same cycle.
module pw_fifo #(
    parameter int  DEPTH = 8,
    parameter int  WIDTH = 18,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full      = (r_count == CNT_MAX);
    assign o_empty     = (r_count == '0);
    assign o_count     = r_count;
    assign o_head_data = r_mem[r_rd_ptr];
    assign w_do_push   = i_push & ~o_full;
    assign w_do_pop    = i_pop & ~o_empty;

    // Storage array write; contents need no reset because count gates reads
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/playfield_writer.sv
// playfield_writer: CPU-side write engine for the 32x32 playfield tile RAM.
// Queues single-tile writes, runs hardware block fills and drives the RAM
// write port with registered signals, one tile per clock.
// Optional build macro PLAYFIELD_WRITER_VBLANK_GATE_EN: when defined, commits
// to the RAM only happen while vblank is high; otherwise vblank is ignored.
module playfield_writer
    import playfield_writer_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int PF_ADDR_W  = PF_ADDR_W_DEFAULT,
    parameter int TILE_W     = TILE_W_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cpu_write,
    input  logic                 cpu_sel,
    input  logic [1:0]           cpu_addr,
    input  logic [15:0]          cpu_wr_data,
    output logic [15:0]          cpu_rd_data,
    input  logic                 vblank,
    output logic                 pf_write,
    output logic [PF_ADDR_W-1:0] pf_write_addr,
    output logic [TILE_W-1:0]    pf_wr_data,
    output logic                 busy
);

    localparam int ENTRY_W = PF_ADDR_W + TILE_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int LEN_W   = PF_ADDR_W + 1;

    localparam logic [PF_ADDR_W-1:0] ADDR_ONE = PF_ADDR_W'(1);
    localparam logic [LEN_W-1:0]     LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0]     LEN_MAX  = {1'b1, {PF_ADDR_W{1'b0}}};

    // CPU-visible registers
    logic [PF_ADDR_W-1:0] r_cursor;
    logic [LEN_W-1:0]     r_fill_len;
    logic                 r_overflow;

    // Fill engine
    pw_state_e            r_state;
    pw_state_e            w_state_next;
    logic [PF_ADDR_W-1:0] r_fill_addr;
    logic [TILE_W-1:0]    r_fill_tile;
    logic [LEN_W-1:0]     r_remaining;
    logic                 w_fill_step;

    // RAM write port
    logic                 r_pf_write;
    logic [PF_ADDR_W-1:0] r_pf_addr;
    logic [TILE_W-1:0]    r_pf_data;
    logic                 w_pf_write_next;
    logic [PF_ADDR_W-1:0] w_pf_addr_next;
    logic [TILE_W-1:0]    w_pf_data_next;

    // Decode and FIFO plumbing
    logic                 w_commit_en;
    logic                 w_sel_cursor;
    logic                 w_sel_data;
    logic                 w_sel_len;
    logic                 w_sel_go;
    logic                 w_push;
    logic                 w_go_ok;
    logic                 w_fifo_pop;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [CNT_W-1:0]     w_fifo_count;
    logic [ENTRY_W-1:0]   w_fifo_head;
    logic [LEN_W-1:0]     w_len_clamped;
    logic                 w_unused;

`ifdef PLAYFIELD_WRITER_VBLANK_GATE_EN
    assign w_commit_en = vblank;
`else
    assign w_commit_en = 1'b1;
`endif

    // Upper data bits and (in the ungated build) vblank have no function
    assign w_unused = ^{vblank, cpu_wr_data};

    assign w_sel_cursor = cpu_write & (cpu_addr == REG_CURSOR);
    assign w_sel_data   = cpu_write & (cpu_addr == REG_DATA);
    assign w_sel_len    = cpu_write & (cpu_addr == REG_FILL_LEN);
    assign w_sel_go     = cpu_write & (cpu_addr == REG_FILL_GO);

    // A DATA write only lands when there was room at the start of the cycle
    assign w_push  = w_sel_data & ~w_fifo_full;
    assign w_go_ok = w_sel_go & (r_state == IDLE) & w_fifo_empty & (r_fill_len != '0);

    assign busy          = ~w_fifo_empty | (r_state == FILL);
    assign pf_write      = r_pf_write;
    assign pf_write_addr = r_pf_addr;
    assign pf_wr_data    = r_pf_data;

    pw_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data ({r_cursor, cpu_wr_data[TILE_W-1:0]}),
        .i_pop       (w_fifo_pop),
        .o_head_data (w_fifo_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    // Clamp a requested fill length to one whole playfield
    always_comb begin
        w_len_clamped = cpu_wr_data[LEN_W-1:0];
        if (cpu_wr_data[LEN_W-1:0] > LEN_MAX) begin
            w_len_clamped = LEN_MAX;
        end else begin
            w_len_clamped = cpu_wr_data[LEN_W-1:0];
        end
    end

    // CPU registers: cursor, fill length and the sticky overflow flag
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cursor   <= '0;
            r_fill_len <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_sel_cursor) begin
                r_cursor   <= cpu_wr_data[PF_ADDR_W-1:0];
                r_overflow <= 1'b0;
            end else if (w_push) begin
                r_cursor <= r_cursor + ADDR_ONE;
            end else if ((w_sel_data & w_fifo_full) | (w_sel_go & ~w_go_ok)) begin
                r_overflow <= 1'b1;
            end
            if (w_sel_len) begin
                r_fill_len <= w_len_clamped;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, FIFO pop and the next RAM-port values for this cycle
    always_comb begin
        w_state_next    = r_state;
        w_fifo_pop      = 1'b0;
        w_fill_step     = 1'b0;
        w_pf_write_next = 1'b0;
        w_pf_addr_next  = r_pf_addr;
        w_pf_data_next  = r_pf_data;
        case (r_state)
            IDLE: begin
                if (w_commit_en && !w_fifo_empty) begin
                    w_fifo_pop      = 1'b1;
                    w_pf_write_next = 1'b1;
                    w_pf_addr_next  = w_fifo_head[ENTRY_W-1:TILE_W];
                    w_pf_data_next  = w_fifo_head[TILE_W-1:0];
                end else begin
                    w_pf_write_next = 1'b0;
                end
                if (w_go_ok) begin
                    w_state_next = FILL;
                end else begin
                    w_state_next = IDLE;
                end
            end
            FILL: begin
                if (w_commit_en) begin
                    w_fill_step     = 1'b1;
                    w_pf_write_next = 1'b1;
                    w_pf_addr_next  = r_fill_addr;
                    w_pf_data_next  = r_fill_tile;
                    if (r_remaining == LEN_ONE) begin
                        w_state_next = IDLE;
                    end else begin
                        w_state_next = FILL;
                    end
                end else begin
                    w_state_next = FILL;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Fill engine: latch on an accepted FILL_GO, advance on each fill write
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_fill_addr <= '0;
            r_fill_tile <= '0;
            r_remaining <= '0;
        end else if (w_go_ok) begin
            r_fill_addr <= r_cursor;
            r_fill_tile <= cpu_wr_data[TILE_W-1:0];
            r_remaining <= r_fill_len;
        end else if (w_fill_step) begin
            r_fill_addr <= r_fill_addr + ADDR_ONE;
            r_remaining <= r_remaining - LEN_ONE;
        end
    end

    // Registered RAM write port
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pf_write <= 1'b0;
            r_pf_addr  <= '0;
            r_pf_data  <= '0;
        end else begin
            r_pf_write <= w_pf_write_next;
            r_pf_addr  <= w_pf_addr_next;
            r_pf_data  <= w_pf_data_next;
        end
    end

    // CPU read mux, zero-extended and forced to zero when not selected
    always_comb begin
        cpu_rd_data = 16'h0000;
        if (cpu_sel) begin
            case (cpu_addr)
                REG_CURSOR:   cpu_rd_data = 16'(r_cursor);
                REG_DATA:     cpu_rd_data = 16'(w_fifo_count);
                REG_FILL_LEN: cpu_rd_data = 16'(r_fill_len);
                REG_FILL_GO:  cpu_rd_data = 16'(pack_status(r_overflow, w_fifo_full,
                                                            w_fifo_empty, busy));
                default:      cpu_rd_data = 16'h0000;
            endcase
        end else begin
            cpu_rd_data = 16'h0000;
        end
    end

endmodule

// File: tb/tb_playfield_writer.sv
// Self-checking bench for playfield_writer: a transaction-level model built
// on a queue shadows the design every cycle, plus a register table and
// hand-written sequences for latency, wrap, overflow, fills and reset.
module tb_playfield_writer;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_write;
    logic        cpu_sel;
    logic [1:0]  cpu_addr;
    logic [15:0] cpu_wr_data;
    logic [15:0] cpu_rd_data;
    logic        vblank;
    logic        pf_write;
    logic [9:0]  pf_write_addr;
    logic [7:0]  pf_wr_data;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    playfield_writer #(.FIFO_DEPTH(DEPTH), .PF_ADDR_W(10), .TILE_W(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .cpu_write     (cpu_write),
        .cpu_sel       (cpu_sel),
        .cpu_addr      (cpu_addr),
        .cpu_wr_data   (cpu_wr_data),
        .cpu_rd_data   (cpu_rd_data),
        .vblank        (vblank),
        .pf_write      (pf_write),
        .pf_write_addr (pf_write_addr),
        .pf_wr_data    (pf_wr_data),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // ---------------- reference model (queue based) ----------------
    logic [17:0] m_q[$];
    logic [9:0]  m_cursor, m_fa, m_pfa;
    logic [7:0]  m_ft, m_pfd;
    int          m_len, m_rem;
    logic        m_ovf, m_pfw;
    bit          m_valid = 1'b0;

    function automatic logic [15:0] model_rd(input logic sel, input logic [1:0] a);
        int n;
        bit b;
        n = m_q.size();
        b = (n > 0) || (m_rem > 0);
        if (!sel) return 16'h0000;
        case (a)
            2'd0:    return {6'd0, m_cursor};
            2'd1:    return 16'(n);
            2'd2:    return 16'(m_len);
            default: return {12'd0, m_ovf, (n == DEPTH), (n == 0), b};
        endcase
    endfunction

    // Model advance on every clock edge
    always @(posedge clock) begin : model_b
        bit          en;
        int          pre;
        bit          idle_pre;
        logic [17:0] e;
        cycle++;
        if (!reset) begin
            m_q.delete();
            m_cursor = 10'd0; m_len = 0; m_ovf = 1'b0; m_rem = 0;
            m_fa = 10'd0; m_ft = 8'd0; m_pfw = 1'b0; m_pfa = 10'd0; m_pfd = 8'd0;
            m_valid = 1'b1;
        end else if (m_valid) begin
`ifdef PLAYFIELD_WRITER_VBLANK_GATE_EN
            en = vblank;
`else
            en = 1'b1;
`endif
            pre      = m_q.size();
            idle_pre = (m_rem == 0);
            m_pfw    = 1'b0;
            if (en) begin
                if (m_rem > 0) begin
                    m_pfw = 1'b1; m_pfa = m_fa; m_pfd = m_ft;
                    m_fa  = m_fa + 10'd1;
                    m_rem = m_rem - 1;
                end else if (pre > 0) begin
                    e = m_q.pop_front();
                    m_pfw = 1'b1; m_pfa = e[17:8]; m_pfd = e[7:0];
                end
            end
            if (cpu_write) begin
                case (cpu_addr)
                    2'd0: begin m_cursor = cpu_wr_data[9:0]; m_ovf = 1'b0; end
                    2'd1: begin
                        if (pre < DEPTH) begin
                            m_q.push_back({m_cursor, cpu_wr_data[7:0]});
                            m_cursor = m_cursor + 10'd1;
                        end else begin
                            m_ovf = 1'b1;
                        end
                    end
                    2'd2: m_len = (cpu_wr_data[10:0] > 11'd1024) ? 1024 : int'(cpu_wr_data[10:0]);
                    default: begin
                        if (idle_pre && pre == 0 && m_len != 0) begin
                            m_rem = m_len; m_fa = m_cursor; m_ft = cpu_wr_data[7:0];
                        end else begin
                            m_ovf = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    typedef struct { int cyc; logic [9:0] a; logic [7:0] d; } wr_t;
    wr_t obs[$];

    // Compare against the model and log RAM writes away from the active edge
    always @(negedge clock) begin
        if (m_valid) begin
            chk("pf_write", pf_write, m_pfw);
            if (m_pfw) begin
                chk("pf_write_addr", pf_write_addr, m_pfa);
                chk("pf_wr_data", pf_wr_data, m_pfd);
            end
            chk("busy", busy, (m_q.size() > 0) || (m_rem > 0));
            chk("cpu_rd_data", cpu_rd_data, model_rd(cpu_sel, cpu_addr));
        end
        if (pf_write === 1'b1) obs.push_back('{cycle, pf_write_addr, pf_wr_data});
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic w, input logic [1:0] a, input logic [15:0] d);
        cpu_write = w; cpu_addr = a; cpu_wr_data = d; cpu_sel = 1'b1;
        @(posedge clock); #2;
        cpu_write = 1'b0;
    endtask

    task automatic idle(input int n, input logic [1:0] ra);
        cpu_write = 1'b0; cpu_addr = ra; cpu_sel = 1'b1;
        repeat (n) begin @(posedge clock); #2; end
    endtask

    task automatic read_reg(input logic [1:0] ra, output logic [15:0] v);
        cpu_write = 1'b0; cpu_sel = 1'b1; cpu_addr = ra;
        @(posedge clock); #3;
        v = cpu_rd_data;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < limit) begin @(posedge clock); #2; k++; end
        chk(name, (k < limit), 1'b1);
        idle(2, 2'd0);
    endtask

    typedef struct { logic [1:0] wa; logic [15:0] wd; logic [1:0] ra; logic [15:0] exp; } vec_t;

    initial begin
        vec_t        tbl[12];
        logic [15:0] v;
        logic [9:0]  exp_a[4];
        int          t0, r;

        tbl[0]  = '{2'd0, 16'h03A0, 2'd0, 16'h03A0};
        tbl[1]  = '{2'd1, 16'h001A, 2'd0, 16'h03A1};
        tbl[2]  = '{2'd1, 16'h001B, 2'd0, 16'h03A2};
        tbl[3]  = '{2'd2, 16'h07FF, 2'd2, 16'h0400};
        tbl[4]  = '{2'd2, 16'h0401, 2'd2, 16'h0400};
        tbl[5]  = '{2'd2, 16'h0400, 2'd2, 16'h0400};
        tbl[6]  = '{2'd2, 16'hF803, 2'd2, 16'h0003};
        tbl[7]  = '{2'd0, 16'hFFFF, 2'd0, 16'h03FF};
        tbl[8]  = '{2'd1, 16'h0005, 2'd0, 16'h0000};
        tbl[9]  = '{2'd2, 16'h0000, 2'd2, 16'h0000};
        tbl[10] = '{2'd3, 16'h0026, 2'd3, 16'h000A};
        tbl[11] = '{2'd0, 16'h0005, 2'd3, 16'h0002};

        reset = 1'b0; cpu_write = 1'b0; cpu_sel = 1'b0; cpu_addr = 2'd0;
        cpu_wr_data = 16'h0000; vblank = 1'b1;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        chk("rst_pf_write", pf_write, 1'b0);
        chk("rst_pf_addr", pf_write_addr, 10'd0);
        chk("rst_pf_data", pf_wr_data, 8'd0);
        chk("rst_busy", busy, 1'b0);
        read_reg(2'd3, v); chk("rst_status", v, 16'h0002);
        read_reg(2'd0, v); chk("rst_cursor", v, 16'h0000);
        cpu_sel = 1'b0; #1; chk("rd_unselected", cpu_rd_data, 16'h0000);

        // Register table
        for (int i = 0; i < 12; i++) begin
            step(1'b1, tbl[i].wa, tbl[i].wd);
            idle(3, 2'd0);
            read_reg(tbl[i].ra, v);
            chk($sformatf("tbl%0d", i), v, tbl[i].exp);
        end

        // Back-to-back DATA writes: latency and one tile per clock
        obs.delete();
        step(1'b1, 2'd0, 16'h03A0);
        step(1'b1, 2'd1, 16'h001A); t0 = cycle;
        step(1'b1, 2'd1, 16'h001B);
        idle(4, 2'd0);
        chk("A_nwr", obs.size(), 2);
        if (obs.size() == 2) begin
            chk("A_addr0", obs[0].a, 10'h3A0); chk("A_data0", obs[0].d, 8'h1A);
            chk("A_addr1", obs[1].a, 10'h3A1); chk("A_data1", obs[1].d, 8'h1B);
            chk("A_latency", obs[0].cyc, t0 + 1);
            chk("A_consecutive", obs[1].cyc, t0 + 2);
        end
        read_reg(2'd0, v); chk("A_cursor", v, 16'h03A2);

        // Cursor wrap 1023 -> 0
        obs.delete();
        step(1'b1, 2'd0, 16'h03FF);
        step(1'b1, 2'd1, 16'h0005);
        idle(3, 2'd0);
        chk("B_nwr", obs.size(), 1);
        if (obs.size() == 1) begin
            chk("B_addr", obs[0].a, 10'h3FF); chk("B_data", obs[0].d, 8'h05);
        end
        read_reg(2'd0, v); chk("B_cursor", v, 16'h0000);

        // Fill of 4 wrapping past the end of the playfield
        exp_a[0] = 10'h3FE; exp_a[1] = 10'h3FF; exp_a[2] = 10'h000; exp_a[3] = 10'h001;
        step(1'b1, 2'd2, 16'h0004);
        step(1'b1, 2'd0, 16'h03FE);
        obs.delete();
        step(1'b1, 2'd3, 16'h0026);
        chk("C_busy_during", busy, 1'b1);
        idle(6, 2'd0);
        chk("C_nwr", obs.size(), 4);
        if (obs.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("C_addr%0d", i), obs[i].a, exp_a[i]);
                chk($sformatf("C_data%0d", i), obs[i].d, 8'h26);
            end
        end
        chk("C_busy_after", busy, 1'b0);
        read_reg(2'd0, v); chk("C_cursor", v, 16'h03FE);

        // FILL_GO while the FIFO holds an entry is refused
        step(1'b1, 2'd2, 16'h0005);
        obs.delete();
        step(1'b1, 2'd1, 16'h0055);
        step(1'b1, 2'd3, 16'h0099);
        read_reg(2'd3, v); chk("D_status", v, 16'h000A);
        idle(10, 2'd0);
        chk("D_nwr", obs.size(), 1);
        if (obs.size() == 1) begin
            chk("D_addr", obs[0].a, 10'h3FE); chk("D_data", obs[0].d, 8'h55);
        end

        // FIFO overflow while a long fill holds off pops
        step(1'b1, 2'd0, 16'h0100);
        step(1'b1, 2'd2, 16'd100);
        obs.delete();
        step(1'b1, 2'd3, 16'h0077);
        for (int i = 0; i < 9; i++) step(1'b1, 2'd1, 16'(16'h00A0 + i));
        read_reg(2'd1, v); chk("E_count", v, 16'd8);
        read_reg(2'd3, v); chk("E_status", v, 16'h000D);
        read_reg(2'd0, v); chk("E_cursor", v, 16'h0108);
        wait_idle("E_done", 400);
        chk("E_nwr", obs.size(), 108);
        if (obs.size() == 108) begin
            for (int i = 0; i < 100; i++) begin
                chk("E_fill_addr", obs[i].a, 10'(10'h100 + i));
                chk("E_fill_data", obs[i].d, 8'h77);
            end
            for (int i = 0; i < 8; i++) begin
                chk("E_q_addr", obs[100 + i].a, 10'(10'h100 + i));
                chk("E_q_data", obs[100 + i].d, 8'(8'hA0 + i));
            end
        end

`ifdef PLAYFIELD_WRITER_VBLANK_GATE_EN
        // Commits held off outside vertical blank
        vblank = 1'b0;
        step(1'b1, 2'd0, 16'h0200);
        obs.delete();
        for (int i = 0; i < 9; i++) step(1'b1, 2'd1, 16'(16'h0030 + i));
        read_reg(2'd1, v); chk("G_count", v, 16'd8);
        read_reg(2'd3, v); chk("G_status", v, 16'h000D);
        read_reg(2'd0, v); chk("G_cursor", v, 16'h0208);
        idle(3, 2'd0);
        chk("G_held", obs.size(), 0);
        vblank = 1'b1;
        idle(12, 2'd0);
        chk("G_nwr", obs.size(), 8);
        if (obs.size() == 8) begin
            for (int i = 0; i < 8; i++) chk("G_addr", obs[i].a, 10'(10'h200 + i));
        end
`endif

        // Reset in the middle of a 100-entry fill
        step(1'b1, 2'd2, 16'd100);
        step(1'b1, 2'd0, 16'h0020);
        step(1'b1, 2'd3, 16'h005A);
        idle(20, 2'd0);
        chk("F_filling", busy, 1'b1);
        reset = 1'b0;
        step(1'b0, 2'd0, 16'h0000);
        reset = 1'b1;
        chk("F_pf_write", pf_write, 1'b0);
        chk("F_busy", busy, 1'b0);
        obs.delete();
        read_reg(2'd3, v); chk("F_status", v, 16'h0002);
        read_reg(2'd2, v); chk("F_len", v, 16'h0000);
        idle(10, 2'd0);
        chk("F_no_writes", obs.size(), 0);

        // Randomized traffic, checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 199));
            cpu_sel = 1'($urandom_range(0, 1));
            vblank  = ($urandom_range(0, 3) != 0);
            cpu_addr = 2'($urandom_range(0, 3));
            cpu_wr_data = 16'($urandom);
            cpu_write = 1'b0;
            if (r < 80) begin
                cpu_write = 1'b1; cpu_addr = 2'd1;
            end else if (r < 90) begin
                cpu_write = 1'b1; cpu_addr = 2'd0;
            end else if (r < 100) begin
                cpu_write = 1'b1; cpu_addr = 2'd2;
                if ($urandom_range(0, 3) != 0) cpu_wr_data = 16'($urandom_range(0, 24));
            end else if (r < 112) begin
                cpu_write = 1'b1; cpu_addr = 2'd3;
            end else if (r == 199) begin
                reset = 1'b0;
            end
            @(posedge clock); #2;
            reset = 1'b1;
            cpu_write = 1'b0;
        end
        vblank = 1'b1;
        wait_idle("R_drain", 2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
